// File: rtl/fp_pkg.sv
// Shared types and constants for the single-precision multiplier datapath
// and its downstream exception stage.
package fp_pkg;

    localparam int BIAS    = 127;
    localparam int EXP_W   = 10;
    localparam int EXP_MAX = 254;
    localparam int EXP_MIN = 1;

    typedef enum logic [2:0] {
        IEEE_NEAR = 3'd0,
        IEEE_ZERO = 3'd1,
        IEEE_PINF = 3'd2,
        IEEE_NINF = 3'd3,
        NEAR_UP   = 3'd4,
        AWAY_ZERO = 3'd5
    } round_t;

endpackage

// File: rtl/fp_mult_pipe_if.sv
// Operand/result handshake bundle of the pipelined multiplier; the master
// side presents operands and consumes results, the slave side is the pipe.
interface fp_mult_pipe_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  round;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] z_calc;
    logic        ovf;
    logic        unf;
    logic        inexact;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [2:0]  round_q;

    modport master (
        output in_valid, a, b, round, out_ready,
        input  in_ready, out_valid, z_calc, ovf, unf, inexact, a_q, b_q, round_q
    );

    modport slave (
        input  in_valid, a, b, round, out_ready,
        output in_ready, out_valid, z_calc, ovf, unf, inexact, a_q, b_q, round_q
    );

endinterface

// File: rtl/round_mult.sv
// Rounding decision for a normalized 23-bit mantissa: picks the increment
// from guard/sticky/sign per rounding mode and applies it.
module round_mult
    import fp_pkg::*;
(
    input  logic [22:0] m,
    input  logic        g,
    input  logic        s,
    input  logic        sign,
    input  logic [2:0]  round,
    output logic [22:0] m_out,
    output logic        carry,
    output logic        inc
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        inc = 1'b0;
        case (round)
            IEEE_NEAR: inc = g & (s | m[0]);
            IEEE_ZERO: inc = 1'b0;
            IEEE_PINF: inc = ~sign & (g | s);
            IEEE_NINF: inc = sign & (g | s);
            NEAR_UP:   inc = g;
            AWAY_ZERO: inc = g | s;
            default:   inc = 1'b0;
        endcase
        // A carry out of bit 22 wraps the mantissa to zero; the caller bumps the exponent.
        {carry, m_out} = {1'b0, m} + 24'(inc);
    end

endmodule

// File: rtl/fp_mult_pipe.sv
// Three-stage single-precision multiply (unpack, normalize, round) with a
// global stall, forwarding operands and mode aligned with the raw product.
module fp_mult_pipe
    import fp_pkg::*;
#(
    parameter int BIAS  = fp_pkg::BIAS,
    parameter int EXP_W = fp_pkg::EXP_W
) (
    input  logic          clk,
    input  logic          rst,
    fp_mult_pipe_if.slave bus
);

    localparam logic signed [EXP_W-1:0] E_MAX = EXP_W'(EXP_MAX);
    localparam logic signed [EXP_W-1:0] E_MIN = EXP_W'(EXP_MIN);

    typedef struct packed {
        logic                    valid;
        logic                    sign;
        logic signed [EXP_W-1:0] e;
        logic [47:0]             p;
        logic [31:0]             a;
        logic [31:0]             b;
        logic [2:0]              rnd;
    } s1_t;

    typedef struct packed {
        logic                    valid;
        logic                    sign;
        logic signed [EXP_W-1:0] e;
        logic [22:0]             m;
        logic                    g;
        logic                    s;
        logic [31:0]             a;
        logic [31:0]             b;
        logic [2:0]              rnd;
    } s2_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] z;
        logic        ovf;
        logic        unf;
        logic        inexact;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  rnd;
    } s3_t;

    s1_t s1_q, s1_d;
    s2_t s2_q, s2_d;
    s3_t s3_q, s3_d;

    logic                    en;
    logic [22:0]             m_rnd;
    logic                    rnd_carry;
    logic                    rnd_inc_unused;
    logic signed [EXP_W-1:0] e_fin;

    // The increment itself is only needed inside the rounder; carry drives the exponent.
    round_mult u_round (
        .m     (s2_q.m),
        .g     (s2_q.g),
        .s     (s2_q.s),
        .sign  (s2_q.sign),
        .round (s2_q.rnd),
        .m_out (m_rnd),
        .carry (rnd_carry),
        .inc   (rnd_inc_unused)
    );

    assign en = ~s3_q.valid | bus.out_ready;

    always_comb begin
        s1_d  = s1_q;
        s2_d  = s2_q;
        s3_d  = s3_q;
        e_fin = s2_q.e + EXP_W'(rnd_carry);

        if (en) begin
            s1_d.valid = bus.in_valid;
            s1_d.sign  = bus.a[31] ^ bus.b[31];
            s1_d.e     = EXP_W'(bus.a[30:23]) + EXP_W'(bus.b[30:23]) - EXP_W'(BIAS);
            s1_d.p     = 48'({1'b1, bus.a[22:0]}) * 48'({1'b1, bus.b[22:0]});
            s1_d.a     = bus.a;
            s1_d.b     = bus.b;
            s1_d.rnd   = bus.round;

            s2_d.valid = s1_q.valid;
            s2_d.sign  = s1_q.sign;
            s2_d.a     = s1_q.a;
            s2_d.b     = s1_q.b;
            s2_d.rnd   = s1_q.rnd;
            if (s1_q.p[47]) begin
                s2_d.m = s1_q.p[46:24];
                s2_d.g = s1_q.p[23];
                s2_d.s = |s1_q.p[22:0];
                s2_d.e = s1_q.e + EXP_W'(1);
            end else begin
                s2_d.m = s1_q.p[45:23];
                s2_d.g = s1_q.p[22];
                s2_d.s = |s1_q.p[21:0];
                s2_d.e = s1_q.e;
            end

            // Exponent is truncated into the packed result even when out of range.
            s3_d.valid   = s2_q.valid;
            s3_d.z       = {s2_q.sign, e_fin[7:0], m_rnd};
            s3_d.ovf     = e_fin > E_MAX;
            s3_d.unf     = e_fin < E_MIN;
            s3_d.inexact = s2_q.g | s2_q.s;
            s3_d.a       = s2_q.a;
            s3_d.b       = s2_q.b;
            s3_d.rnd     = s2_q.rnd;
        end
    end

    // NOTE: state registers use non-blocking assignment so every stage samples its predecessor's old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign bus.in_ready  = en;
    assign bus.out_valid = s3_q.valid;
    assign bus.z_calc    = s3_q.z;
    assign bus.ovf       = s3_q.ovf;
    assign bus.unf       = s3_q.unf;
    assign bus.inexact   = s3_q.inexact;
    assign bus.a_q       = s3_q.a;
    assign bus.b_q       = s3_q.b;
    assign bus.round_q   = s3_q.rnd;

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Directed bench for fp_mult_pipe: latency, rounding modes, range flags,
// backpressure, bubbles and mid-flight reset against hand-computed values.
module tb_fp_mult_pipe;
    import fp_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fp_mult_pipe_if bus ();

    fp_mult_pipe dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation, confirm nothing emerges early, then check it exactly 3 cycles later.
    task automatic run_op(input string tag, input logic [31:0] op_a, input logic [31:0] op_b,
                          input logic [2:0] rnd, input logic [31:0] ez,
                          input logic eo, input logic eu, input logic ei);
        bus.in_valid = 1'b1;
        bus.a        = op_a;
        bus.b        = op_b;
        bus.round    = rnd;
        #1;
        check({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        bus.a        = ~op_a;
        bus.b        = ~op_b;
        bus.round    = ~rnd;
        tick();
        check({tag, ".early"}, 32'(bus.out_valid), 32'd0);
        tick();
        check({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, ".z"}, bus.z_calc, ez);
        check({tag, ".flags"}, 32'({bus.ovf, bus.unf, bus.inexact}), 32'({eo, eu, ei}));
        check({tag, ".a_q"}, bus.a_q, op_a);
        check({tag, ".b_q"}, bus.b_q, op_b);
        check({tag, ".round_q"}, 32'(bus.round_q), 32'(rnd));
        tick();
    endtask

    logic [31:0] bp_b [6];
    logic [31:0] held_z;
    logic        was_stall;
    int          sent;
    int          got;
    int          ready_low;
    logic [0:6]  iv_pat;
    logic [0:6]  ov_exp;

    initial begin
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.round     = '0;
        bus.out_ready = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("reset.out_valid", 32'(bus.out_valid), 32'd0);
        check("reset.z", bus.z_calc, 32'd0);
        check("reset.aux", {bus.a_q[15:0], bus.b_q[15:0]} | bus.a_q | bus.b_q, 32'd0);
        check("reset.flags", 32'({bus.ovf, bus.unf, bus.inexact, bus.round_q}), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("reset.in_ready", 32'(bus.in_ready), 32'd1);
        tick();

        // 1.5 * 2.0
        run_op("basic", 32'h3FC00000, 32'h40000000, IEEE_NEAR, 32'h40400000, 1'b0, 1'b0, 1'b0);

        // (1 + 2^-23)^2: guard 0, sticky 1, lsb 0
        run_op("near",   32'h3F800001, 32'h3F800001, IEEE_NEAR, 32'h3F800002, 1'b0, 1'b0, 1'b1);
        run_op("zero",   32'h3F800001, 32'h3F800001, IEEE_ZERO, 32'h3F800002, 1'b0, 1'b0, 1'b1);
        run_op("pinf",   32'h3F800001, 32'h3F800001, IEEE_PINF, 32'h3F800003, 1'b0, 1'b0, 1'b1);
        run_op("ninf",   32'h3F800001, 32'h3F800001, IEEE_NINF, 32'h3F800002, 1'b0, 1'b0, 1'b1);
        run_op("nearup", 32'h3F800001, 32'h3F800001, NEAR_UP,   32'h3F800002, 1'b0, 1'b0, 1'b1);
        run_op("away",   32'h3F800001, 32'h3F800001, AWAY_ZERO, 32'h3F800003, 1'b0, 1'b0, 1'b1);
        run_op("undef",  32'h3F800001, 32'h3F800001, 3'd7,      32'h3F800002, 1'b0, 1'b0, 1'b1);
        run_op("neg.ninf", 32'hBF800001, 32'h3F800001, IEEE_NINF, 32'hBF800003, 1'b0, 1'b0, 1'b1);
        run_op("neg.pinf", 32'hBF800001, 32'h3F800001, IEEE_PINF, 32'hBF800002, 1'b0, 1'b0, 1'b1);

        // sqrt2^2: mantissa all ones, rounding up carries into the exponent
        run_op("carry.near", 32'h3FB504F3, 32'h3FB504F3, IEEE_NEAR, 32'h3FFFFFFF, 1'b0, 1'b0, 1'b1);
        run_op("carry.away", 32'h3FB504F3, 32'h3FB504F3, AWAY_ZERO, 32'h40000000, 1'b0, 1'b0, 1'b1);

        // Exponent range boundaries
        run_op("ovf",    32'h7F000000, 32'h7F000000, IEEE_NEAR, 32'h3E800000, 1'b1, 1'b0, 1'b0);
        run_op("unf",    32'h00800000, 32'h00800000, IEEE_NEAR, 32'h41800000, 1'b0, 1'b1, 1'b0);
        run_op("e254",   32'h7F000000, 32'h3F800000, IEEE_NEAR, 32'h7F000000, 1'b0, 1'b0, 1'b0);
        run_op("e255",   32'h7F000000, 32'h40000000, IEEE_NEAR, 32'h7F800000, 1'b1, 1'b0, 1'b0);
        run_op("e1",     32'h00800000, 32'h3F800000, IEEE_NEAR, 32'h00800000, 1'b0, 1'b0, 1'b0);

        // Backpressure: 1.0 * b_i == b_i exactly, out_ready low in cycles 2..8
        for (int i = 0; i < 6; i++) bp_b[i] = 32'h40000000 + (32'(i) << 20);
        sent      = 0;
        got       = 0;
        ready_low = 0;
        was_stall = 1'b0;
        held_z    = '0;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            bus.out_ready = !(cyc >= 2 && cyc <= 8);
            bus.in_valid  = (sent < 6);
            bus.a         = 32'h3F800000;
            bus.b         = (sent < 6) ? bp_b[sent] : 32'h0;
            bus.round     = IEEE_NEAR;
            #1;
            if (was_stall) check("bp.hold", bus.z_calc, held_z);
            if (!bus.in_ready) begin
                ready_low++;
                check("bp.inflight", 32'(sent - got), 32'd3);
            end
            if (bus.out_valid && bus.out_ready) begin
                check("bp.order", bus.z_calc, bp_b[got]);
                got++;
            end
            was_stall = bus.out_valid && !bus.out_ready;
            held_z    = bus.z_calc;
            if (bus.in_valid && bus.in_ready) sent++;
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        check("bp.sent", 32'(sent), 32'd6);
        check("bp.got", 32'(got), 32'd6);
        check("bp.ready_low", 32'(ready_low), 32'd6);
        check("bp.drained", 32'(bus.out_valid), 32'd0);
        tick();

        // Bubbles: input pattern 1,0,1,0 reappears at the output 3 cycles later
        iv_pat = 7'b1010000;
        ov_exp = 7'b0001010;
        for (int t = 0; t < 7; t++) begin
            bus.in_valid = iv_pat[t];
            bus.a        = 32'h40000000;
            bus.b        = 32'h40000000;
            #1;
            check("bubble", 32'(bus.out_valid), 32'(ov_exp[t]));
            tick();
        end
        bus.in_valid = 1'b0;
        tick();

        // Reset with one result held and two operations in flight
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1'b1;
            bus.a        = 32'h40400000 + 32'(k);
            bus.b        = 32'h40400000;
            bus.round    = AWAY_ZERO;
            tick();
        end
        bus.in_valid = 1'b0;
        check("rst.pre_valid", 32'(bus.out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst.out_valid", 32'(bus.out_valid), 32'd0);
        check("rst.z", bus.z_calc, 32'd0);
        check("rst.a_q", bus.a_q, 32'd0);
        check("rst.b_q", bus.b_q, 32'd0);
        check("rst.flags", 32'({bus.ovf, bus.unf, bus.inexact, bus.round_q}), 32'd0);
        tick();
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        check("rst.in_ready", 32'(bus.in_ready), 32'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rst.no_stale", 32'(bus.out_valid), 32'd0);
        end
        run_op("post_rst", 32'h40400000, 32'h40400000, IEEE_NEAR, 32'h41100000, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_mult_pipe.md
Name: fp_mult_pipe

Overview:
- Three-stage pipelined IEEE-754 single-precision multiply datapath, directly upstream of the multiplier exception stage.
- Produces the raw packed product z_calc plus ovf/unf/inexact flags from a, b and the rounding mode.
- Forwards a, b and round cycle-aligned with the result, so the exception stage can classify operands and override z.
- Uses a valid/ready handshake with full-pipeline stall on backpressure.

Parameters:
- BIAS, 127, exponent bias.
- EXP_W, 10, signed internal exponent width; must hold the range -126..+383.

Ports:
- clk  in  1  clock; all registers update on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand set presented.
- in_ready  out  1  pipeline accepts the operand set this cycle.
- a  in  32  operand A.
- b  in  32  operand B.
- round  in  3  rounding mode (round_t).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- z_calc  out  32  {sign, exp[7:0], mant[22:0]} of the rounded product.
- ovf  out  1  final exponent > 254.
- unf  out  1  final exponent < 1.
- inexact  out  1  guard|sticky nonzero.
- a_q  out  32  a aligned with z_calc.
- b_q  out  32  b aligned with z_calc.
- round_q  out  3  round aligned with z_calc.

Behaviour:
- Reset: every valid bit and every output (including a_q, b_q, round_q, z_calc, flags) is 0 asynchronously. In-flight data is discarded. in_ready = 1 once rst deasserts.
- Stall: en = !out_valid | out_ready; in_ready = en.
  - en=0: all three stages hold their contents.
  - en=1: every stage advances; stage1 loads in_valid with the operands, and a bubble (valid=0) advances like data.
- Transfer: a transfer occurs when in_valid & in_ready. Latency is exactly 3 cycles with no stall, throughput 1 per cycle. Outputs hold stable while out_valid & !out_ready.
- S1 (unpack):
  - sign = a[31]^b[31].
  - e = a[30:23] + b[30:23] - BIAS, sign-extended to EXP_W.
  - P = {1,a[22:0]} * {1,b[22:0]}, 48 bits unsigned.
  - The hidden bit is always 1; specials and subnormals yield deterministic but meaningless z_calc, which downstream overrides.
- S2 (normalize):
  - If P[47]=1: m=P[46:24], g=P[23], s=|P[22:0], e=e+1.
  - Otherwise: m=P[45:23], g=P[22], s=|P[21:0].
- S3 (round): increment inc per mode, with lsb=m[0]:
  - IEEE_NEAR: g&(s|lsb)
  - IEEE_ZERO: 0
  - IEEE_PINF: !sign&(g|s)
  - IEEE_NINF: sign&(g|s)
  - NEAR_UP: g
  - AWAY_ZERO: g|s
  - Undefined codes behave as IEEE_ZERO.
- Post-round: m+inc carrying out of bit 22 gives m=0 and e=e+1.
  - ovf = (e>254); unf = (e<1) as signed compare; inexact = g|s.
  - z_calc = {sign, e[7:0], m}, with the exponent truncated even when ovf/unf is set.
- Registers: flags and a_q/b_q/round_q are registered at the S3 boundary alongside z_calc.
- Simultaneous events: an output handshake and an input transfer in the same cycle are both accepted. Full pipeline with out_ready=0 drops in_ready in the same cycle, combinationally, with no loss or duplication.
- Reset asserted mid-stall clears everything; no result is emitted for the dropped operands.

Decomposition:
- Shared package fp_pkg holds:
  - typedef enum logic [2:0] round_t: IEEE_NEAR=0, IEEE_ZERO=1, IEEE_PINF=2, IEEE_NINF=3, NEAR_UP=4, AWAY_ZERO=5.
  - Constants BIAS, EXP_MAX=254, EXP_MIN=1.
- The exception stage imports the same package.
- One combinational sub-module, round_mult, takes (m, g, s, sign, round) and returns (m_out, carry, inc). The S3 logic wraps it.

Test Plan:
1. 0x3FC00000 * 0x40000000, IEEE_NEAR, out_ready=1 -> z_calc=0x40400000 exactly 3 cycles later; ovf=unf=inexact=0; a_q/b_q/round_q echo the inputs.
2. 0x3F800001 * 0x3F800001 in each mode -> IEEE_NEAR/IEEE_ZERO/NEAR_UP/IEEE_NINF give 0x3F800002; IEEE_PINF/AWAY_ZERO give 0x3F800003; inexact=1 in all modes.
3. 0x7F000000 * 0x7F000000 -> ovf=1, unf=0. Then 0x00800000 * 0x00800000 -> unf=1, ovf=0.
4. Backpressure: 6 back-to-back inputs with out_ready=0 from cycle 2 to cycle 8 -> in_ready falls once 3 results are held; out_valid is held with stable outputs; all 6 results emerge in order with none lost or duplicated.
5. Bubbles: in_valid pattern 1,0,1,0 -> out_valid shows the same pattern 3 cycles later.
6. rst pulsed while 2 operations are in flight -> all outputs 0 immediately, no stale out_valid after release, and the next operation completes normally 3 cycles after issue.
